bsg_concentrate_static_pipe: RTL

BSG_CONCENTRATE_STATIC_PIPE -- requirements
Module: bsg_concentrate_static_pipe

---
 rtl/bsg_concentrate_static_pipe.sv | 115 +++++++++++
 1 files changed

// File: rtl/bsg_concentrate_static_pipe.sv
// Sparse-to-dense lane concentrator with a statically chosen keep mask and a
// two-entry output buffer, plus a sticky error for data on dropped lanes.
module bsg_concentrate_static_pipe #(
  parameter int                 els_p         = 32,
  parameter int                 width_p       = 1,
  parameter logic [els_p-1:0]   pattern_els_p = 32'hEDBF_EDB9
) (
  input  logic                                            clk_i,
  input  logic                                            reset_n_i,
  input  logic                                            v_i,
  input  logic [els_p*width_p-1:0]                        data_i,
  output logic                                            ready_o,
  output logic                                            v_o,
  output logic [$countones(pattern_els_p)*width_p-1:0]    data_o,
  input  logic                                            yumi_i,
  input  logic                                            clr_err_i,
  output logic                                            err_o,
  output logic [15:0]                                     count_o
);

  localparam int dense_els_lp = $countones(pattern_els_p);
  localparam int sparse_w_lp  = els_p * width_p;
  localparam int dense_w_lp   = dense_els_lp * width_p;

  if (dense_els_lp < 1) begin : g_bad_pattern
    $error("pattern_els_p must keep at least one lane");
  end

  // Index of the j-th set bit of the keep mask, counted from bit 0.
  function automatic int sparse_idx(input int j);
    int n;
    int r;
    n = 0;
    r = 0;
    for (int k = 0; k < els_p; k++) begin
      if (pattern_els_p[k]) begin
        if (n == j) r = k;
        n = n + 1;
      end
    end
    return r;
  endfunction

  function automatic logic [sparse_w_lp-1:0] drop_bits();
    logic [sparse_w_lp-1:0] res;
    res = '0;
    for (int k = 0; k < els_p; k++) begin
      res[k*width_p +: width_p] = {width_p{~pattern_els_p[k]}};
    end
    return res;
  endfunction

  localparam logic [sparse_w_lp-1:0] drop_mask_lp = drop_bits();

  // Stage p0: lane concentration and dropped-lane detection on the sparse input
  logic [dense_w_lp-1:0] dense_p0;
  logic                  drop_hit_p0;

  for (genvar j = 0; j < dense_els_lp; j++) begin : g_map
    localparam int k_lp = sparse_idx(j);
    assign dense_p0[j*width_p +: width_p] = data_i[k_lp*width_p +: width_p];
  end

  assign drop_hit_p0 = |(data_i & drop_mask_lp);

  // Stage p1: two-entry buffer of concentrated words
  logic [dense_w_lp-1:0] mem_p1 [2];
  logic [1:0]            occ_p1;
  logic                  wr_ptr_p1;
  logic                  rd_ptr_p1;
  logic                  vld_p1;
  logic                  full;
  logic                  enq;
  logic                  deq;
  logic                  err_p1;
  logic [15:0]           count_p1;

  assign full    = (occ_p1 == 2'd2);
  assign vld_p1  = (occ_p1 != 2'd0);
  assign ready_o = reset_n_i & ~full;
  assign enq     = v_i & ready_o;
  assign deq     = yumi_i & vld_p1 & reset_n_i;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      occ_p1    <= 2'd0;
      wr_ptr_p1 <= 1'b0;
      rd_ptr_p1 <= 1'b0;
      err_p1    <= 1'b0;
      count_p1  <= 16'd0;
    end else begin
      if (enq) wr_ptr_p1 <= ~wr_ptr_p1;
      if (deq) rd_ptr_p1 <= ~rd_ptr_p1;
      case ({enq, deq})
        2'b10:   occ_p1 <= occ_p1 + 2'd1;
        2'b01:   occ_p1 <= occ_p1 - 2'd1;
        default: occ_p1 <= occ_p1;
      endcase
      // A new error word outranks a simultaneous clear.
      if (enq && drop_hit_p0) err_p1 <= 1'b1;
      else if (clr_err_i)     err_p1 <= 1'b0;
      if (enq) count_p1 <= count_p1 + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) mem_p1[wr_ptr_p1] <= dense_p0;
  end

  assign v_o     = vld_p1;
  assign data_o  = mem_p1[rd_ptr_p1];
  assign err_o   = err_p1;
  assign count_o = count_p1;

endmodule
